// File: rtl/adder_tree_seq_pkg.sv
// Shared definitions for the time-multiplexed mod-p adder tree.
// Field is GF(2^61-1); state encoding and the level-halving helper live here.
package adder_tree_seq_pkg;

  localparam int F_NBITS = 61;
  localparam logic [F_NBITS-1:0] PRIME = {F_NBITS{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of elements left after one reduction level.
  function automatic logic [31:0] ceil_half(input logic [31:0] x);
    return (x >> 1) + {31'd0, x[0]};
  endfunction

endpackage

// File: rtl/adder_tree_seq_field_add_p.sv
// Combinational adder modulo p = 2^61-1; operands must already be < p.
module field_add_p
  import adder_tree_seq_pkg::*;
(
  input  logic [F_NBITS-1:0] a,
  input  logic [F_NBITS-1:0] b,
  output logic [F_NBITS-1:0] sum
);

  logic [F_NBITS:0] raw;
  logic [F_NBITS:0] reduced;

  always_comb begin
    raw     = {1'b0, a} + {1'b0, b};
    reduced = raw - {1'b0, PRIME};
    sum     = (raw >= {1'b0, PRIME}) ? reduced[F_NBITS-1:0] : raw[F_NBITS-1:0];
  end

endmodule

// File: rtl/adder_tree_seq.sv
// Reduces ngates field elements with nadders shared mod-p adders, level by level.
// Optional run-cycle counter port enabled by macro ADDER_TREE_SEQ_CYCLES_EN.
module adder_tree_seq
  import adder_tree_seq_pkg::*;
#(
  parameter int ngates  = 8,
  parameter int nadders = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [ngates*F_NBITS-1:0] v_parts,
  output logic                      ready,
  output logic                      done,
  output logic [F_NBITS-1:0]        v
`ifdef ADDER_TREE_SEQ_CYCLES_EN
  ,
  output logic [31:0]               cycles
`endif
);

  // Wide enough for k + nadders and for the doubled read index 2j+1.
  localparam int IW = $clog2(ngates + nadders + 1) + 2;

  state_t state, state_next;
  logic [IW-1:0] n, k, half;
  logic          last_step;
  logic          accept;
  logic [F_NBITS-1:0] bank [ngates];

  logic [IW-1:0]                   op_j   [nadders];
  logic [nadders-1:0]              op_act;
  logic [nadders-1:0][F_NBITS-1:0] add_a, add_b, add_s;

  always_comb begin
    half      = IW'(ceil_half(32'(n)));
    last_step = (k + IW'(nadders)) >= half;
    for (int a = 0; a < nadders; a++) begin
      op_j[a]   = k + IW'(a);
      op_act[a] = (state == RUN) && (op_j[a] < half);
      add_a[a]  = '0;
      add_b[a]  = '0;
      // Odd level: the missing partner stays zero, so the last element passes through.
      for (int i = 0; i < ngates; i++) begin
        if ((op_j[a] << 1) == IW'(i))
          add_a[a] = bank[i];
        if (((op_j[a] << 1) + IW'(1)) == IW'(i) && IW'(i) < n)
          add_b[a] = bank[i];
      end
    end
  end

  for (genvar gi = 0; gi < nadders; gi++) begin : g_add
    field_add_p u_add (
      .a   (add_a[gi]),
      .b   (add_b[gi]),
      .sum (add_s[gi])
    );
  end

  always_comb begin
    state_next = state;
    ready      = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start)
          state_next = (ngates == 1) ? DONE : RUN;
      end
      RUN: begin
        if (last_step && half == IW'(1))
          state_next = DONE;
      end
      DONE: begin
        ready      = 1'b1;
        done       = 1'b1;
        state_next = start ? ((ngates == 1) ? DONE : RUN) : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign accept = start && ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      n     <= '0;
      k     <= '0;
      v     <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        n <= IW'(ngates);
        k <= '0;
        if (ngates == 1)
          v <= v_parts[F_NBITS-1:0];
      end else if (state == RUN) begin
        if (last_step) begin
          n <= half;
          k <= '0;
          if (half == IW'(1))
            v <= add_s[0];
        end else begin
          k <= k + IW'(nadders);
        end
      end
    end
  end

  // In-place writes are safe: op j only reads slots 2j and 2j+1, both >= j.
  always_ff @(posedge clk) begin
    for (int i = 0; i < ngates; i++) begin
      if (accept) begin
        bank[i] <= v_parts[i*F_NBITS +: F_NBITS];
      end else begin
        for (int a = 0; a < nadders; a++)
          if (op_act[a] && op_j[a] == IW'(i))
            bank[i] <= add_s[a];
      end
    end
  end

`ifdef ADDER_TREE_SEQ_CYCLES_EN
  logic [31:0] cycle_count;

  always_ff @(posedge clk) begin
    if (rst)
      cycle_count <= '0;
    else if (accept)
      cycle_count <= '0;
    else if (state == RUN)
      cycle_count <= cycle_count + 32'd1;
  end

  assign cycles = cycle_count;
`endif

endmodule
